pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register that generalises the fixed 32-bit IF/ID latch to any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Width is a parameter.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream ready is fully registered.
- Flush squashes every held entry into a bubble. A bubble is a configurable NOP/zero pattern.
- Provides occupancy and squash-count visibility for the hazard unit and for debug.

Parameters:
DATA_W, 64, payload width in bits (e.g. instruction plus PC = 64 for IF/ID).
BUBBLE_VAL, '0, value driven on out_data whenever out_valid=0, and the value loaded on flush or reset.
CNT_W, 8, width of squash_cnt.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream presents in_data
in_ready  out  1  registered; stage can accept this cycle
in_data  in  DATA_W  upstream payload
flush  in  1  squash all held entries (branch taken / exception)
out_valid  out  1  out_data is a real entry
out_ready  in  1  downstream accepts (0 = stall from hazard unit)
out_data  out  DATA_W  payload of head entry, BUBBLE_VAL when empty
occ  out  2  entries held: 0, 1 or 2
squash_cnt  out  CNT_W  count of valid entries discarded by flush, saturating

Behaviour:
- Transfers:
  - Input transfer (acc) = in_valid & in_ready.
  - Output transfer (pop) = out_valid & out_ready.
- Storage: main register (head, drives out_data/out_valid) and skid register.
- States: EMPTY (occ=0), ONE (occ=1, main valid), TWO (occ=2, main and skid valid).
- in_ready is a register equal to (next state != TWO). It never depends combinationally on out_ready.
- Transitions when flush=0:
  - EMPTY: acc -> ONE, main<=in_data (visible at out_data next cycle; latency 1).
  - ONE: acc&pop -> ONE, main<=in_data. acc&!pop -> TWO, skid<=in_data. !acc&pop -> EMPTY. Otherwise hold.
  - TWO (in_ready=0, so acc=0): pop -> ONE, main<=skid. Otherwise hold.
- Ordering is strictly FIFO. No entry is duplicated or dropped without flush.
- Stall: out_ready=0 holds out_data/out_valid stable for every stalled cycle.
- Flush (priority over all else):
  - Next state EMPTY; main and skid both take BUBBLE_VAL; in_ready<=1.
  - An input handshake completing in the flush cycle is discarded.
  - A pop in the flush cycle still completes downstream (downstream samples the pre-flush head).
- squash_cnt on flush:
  - Adds the number of valid entries discarded: held entries not popped that cycle, plus 1 if acc.
  - Saturates at all-ones.
- Reset, and on every rst cycle:
  - State EMPTY, out_valid=0, out_data=BUBBLE_VAL, skid=BUBBLE_VAL, in_ready=1, occ=0, squash_cnt=0.
  - rst overrides flush and any handshake.
  - Reset mid-TWO discards both entries without counting.
- out_data is BUBBLE_VAL whenever out_valid=0. Stale payload is never exposed.
- occ equals the number of valid entries (main valid + skid valid) at all times.

Decomposition:
- Shared package pipe_pkg:
  - Typedef occ_t (2-bit state/occupancy encoding EMPTY/ONE/TWO).
  - Constant NOP_INSTR (32'h0000_0000) for BUBBLE_VAL construction.
  - Per-stage payload width constants IF_ID_W, ID_EX_W.
- One natural sub-module: sat_counter (parametrised width, add 0..2, saturating) for squash_cnt.
- Everything else lives in pipe_stage_reg.

Test Plan:
- Reset then stream 0x11,0x22,0x33 with out_ready=1 each cycle -> out_data 0x11,0x22,0x33 one cycle after each accept, occ=1, in_ready stays 1.
- Accept 0xA1, then 0xA2 with out_ready=0 -> occ=2, in_ready=0 next cycle, out_data held 0xA1. Then out_ready=1 for two cycles -> pops 0xA1 then 0xA2, occ back to 0.
- In TWO state, assert flush with out_ready=0 -> next cycle occ=0, out_valid=0, out_data=BUBBLE_VAL, in_ready=1, squash_cnt=2.
- In ONE state, flush together with acc of 0x55 and pop of head -> head counted as delivered, 0x55 dropped, squash_cnt+=1, state EMPTY.
- Preload squash_cnt to 0xFF (CNT_W=8), flush with 2 held -> squash_cnt stays 0xFF.
- rst asserted while in TWO with flush=1 -> all outputs at reset values, squash_cnt=0, no data leaks out after rst drops.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy encoding,
// the NOP instruction used to build bubbles, and per-boundary payload widths.
package pipe_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // IF/ID carries instruction + PC; ID/EX carries two operands, PC and control.
   localparam int IF_ID_W = 64;
   localparam int ID_EX_W = 128;

   // Number of entries discarded by a flush: held entries not popped, plus a
   // concurrent accept. Never exceeds 2 because accept is blocked when full.
   function automatic logic [1:0] squash_amount(input occ_t occ, input logic pop,
                                                input logic acc);
      logic [1:0] held;
      held = occ;
      return held - {1'b0, pop} + {1'b0, acc};
   endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter adding 0..2 per cycle; sticks at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic [W:0]   sum;

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      sum     = {1'b0, count_q} + (W+1)'(inc);
      count_d = count_q;
      if (sum[W]) count_d = '1;
      else        count_d = sum[W-1:0];
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready with a 2-entry skid buffer so
// in_ready is registered; flush turns every held entry into a bubble.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = 64,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
   parameter int                CNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occ,
   output logic [CNT_W-1:0]  squash_cnt
);

   occ_t              state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready_q, in_ready_d;
   logic              acc;
   logic              pop;
   logic [1:0]        squash_inc;

   assign acc = in_valid & in_ready_q;
   assign pop = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = OCC_EMPTY;
         main_d  = BUBBLE_VAL;
         skid_d  = BUBBLE_VAL;
      end else begin
         case (state_q)
            OCC_EMPTY: begin
               if (acc) begin
                  state_d = OCC_ONE;
                  main_d  = in_data;
               end
            end
            OCC_ONE: begin
               if (acc && pop) begin
                  main_d = in_data;
               end else if (acc) begin
                  state_d = OCC_TWO;
                  skid_d  = in_data;
               end else if (pop) begin
                  // Leaving the head as a bubble keeps stale payload off out_data.
                  state_d = OCC_EMPTY;
                  main_d  = BUBBLE_VAL;
               end
            end
            OCC_TWO: begin
               if (pop) begin
                  state_d = OCC_ONE;
                  main_d  = skid_q;
                  skid_d  = BUBBLE_VAL;
               end
            end
            default: begin
               state_d = OCC_EMPTY;
               main_d  = BUBBLE_VAL;
               skid_d  = BUBBLE_VAL;
            end
         endcase
      end
      // Registered ready: decided from the next state, never from out_ready.
      in_ready_d = (state_d != OCC_TWO);
   end

   // NOTE: the payload registers are reset (not left to power-up contents)
   // because out_data is architecturally visible and must read BUBBLE_VAL.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= OCC_EMPTY;
         main_q     <= BUBBLE_VAL;
         skid_q     <= BUBBLE_VAL;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   always_comb begin
      squash_inc = 2'd0;
      if (flush) squash_inc = squash_amount(state_q, pop, acc);
   end

   sat_counter #(
      .W (CNT_W)
   ) u_squash_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (squash_inc),
      .count (squash_cnt)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != OCC_EMPTY);
   assign out_data  = main_q;
   assign occ       = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: hand-derived vector table plus a FIFO scoreboard
// that follows every accept, pop, flush and reset seen on the ports.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int                 DW     = IF_ID_W;
   localparam logic [DW-1:0]      BUBBLE = {32'hBBBB_0000, NOP_INSTR};

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [1:0]    occ;
   logic [7:0]    squash_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_stage_reg #(
      .DATA_W     (DW),
      .BUBBLE_VAL (BUBBLE),
      .CNT_W      (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .occ        (occ),
      .squash_cnt (squash_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, let the edge happen, return 1 time unit later.
   task automatic drive(input logic r, input logic iv, input logic [DW-1:0] d,
                        input logic fl, input logic ordy);
      rst       = r;
      in_valid  = iv;
      in_data   = d;
      flush     = fl;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic ev, input logic [DW-1:0] ed,
                             input logic [1:0] eocc, input logic erdy, input logic [7:0] esq);
      check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
      check({tag, ".out_data"}, out_data, ed);
      check({tag, ".occ"}, 64'(occ), 64'(eocc));
      check({tag, ".in_ready"}, 64'(in_ready), 64'(erdy));
      check({tag, ".squash_cnt"}, 64'(squash_cnt), 64'(esq));
   endtask

   // ---------------- scoreboard ----------------
   logic [DW-1:0] sb_q[$];
   int            sb_sq = 0;
   bit            mon_en = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         logic acc_s, pop_s;
         int   n;
         check("sb.occ", 64'(occ), 64'(sb_q.size()));
         check("sb.out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
         check("sb.in_ready", 64'(in_ready), 64'(sb_q.size() != 2));
         check("sb.squash_cnt", 64'(squash_cnt), 64'(sb_sq));
         if (sb_q.size() == 0) check("sb.bubble", out_data, BUBBLE);
         else                  check("sb.head", out_data, sb_q[0]);
         acc_s = in_valid & in_ready;
         pop_s = out_valid & out_ready;
         if (rst) begin
            sb_q.delete();
            sb_sq = 0;
         end else begin
            if (pop_s && sb_q.size() != 0) void'(sb_q.pop_front());
            if (flush) begin
               n = sb_q.size() + (acc_s ? 1 : 0);
               sb_sq = (sb_sq + n > 255) ? 255 : sb_sq + n;
               sb_q.delete();
            end else if (acc_s) begin
               sb_q.push_back(in_data);
            end
         end
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic          iv;
      logic [DW-1:0] d;
      logic          fl;
      logic          ordy;
      logic          ev;
      logic [DW-1:0] ed;
      logic [1:0]    eocc;
      logic          erdy;
      logic [7:0]    esq;
   } vec_t;

   vec_t vecs[18];

   initial begin
      //            iv  data    fl  ordy  ev  exp data  occ  rdy  sq
      vecs[0]  = '{1'b1, 64'h11, 1'b0, 1'b1, 1'b1, 64'h11, 2'd1, 1'b1, 8'd0};
      vecs[1]  = '{1'b1, 64'h22, 1'b0, 1'b1, 1'b1, 64'h22, 2'd1, 1'b1, 8'd0};
      vecs[2]  = '{1'b1, 64'h33, 1'b0, 1'b1, 1'b1, 64'h33, 2'd1, 1'b1, 8'd0};
      vecs[3]  = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b0, BUBBLE, 2'd0, 1'b1, 8'd0};
      vecs[4]  = '{1'b1, 64'hA1, 1'b0, 1'b0, 1'b1, 64'hA1, 2'd1, 1'b1, 8'd0};
      vecs[5]  = '{1'b1, 64'hA2, 1'b0, 1'b0, 1'b1, 64'hA1, 2'd2, 1'b0, 8'd0};
      vecs[6]  = '{1'b1, 64'hA3, 1'b0, 1'b0, 1'b1, 64'hA1, 2'd2, 1'b0, 8'd0};
      vecs[7]  = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b1, 64'hA2, 2'd1, 1'b1, 8'd0};
      vecs[8]  = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b0, BUBBLE, 2'd0, 1'b1, 8'd0};
      vecs[9]  = '{1'b1, 64'hB1, 1'b0, 1'b0, 1'b1, 64'hB1, 2'd1, 1'b1, 8'd0};
      vecs[10] = '{1'b1, 64'hB2, 1'b0, 1'b0, 1'b1, 64'hB1, 2'd2, 1'b0, 8'd0};
      vecs[11] = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, BUBBLE, 2'd0, 1'b1, 8'd2};
      vecs[12] = '{1'b1, 64'hC1, 1'b0, 1'b0, 1'b1, 64'hC1, 2'd1, 1'b1, 8'd2};
      vecs[13] = '{1'b1, 64'h55, 1'b1, 1'b1, 1'b0, BUBBLE, 2'd0, 1'b1, 8'd3};
      vecs[14] = '{1'b1, 64'h66, 1'b1, 1'b1, 1'b0, BUBBLE, 2'd0, 1'b1, 8'd4};
      vecs[15] = '{1'b1, 64'h77, 1'b0, 1'b1, 1'b1, 64'h77, 2'd1, 1'b1, 8'd4};
      vecs[16] = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h77, 2'd1, 1'b1, 8'd4};
      vecs[17] = '{1'b0, 64'h0,  1'b0, 1'b1, 1'b0, BUBBLE, 2'd0, 1'b1, 8'd4};
   end

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      #1;
      drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
      mon_en = 1;
      drive(1'b1, 1'b1, 64'hFF, 1'b1, 1'b1);
      check_outs("reset", 1'b0, BUBBLE, 2'd0, 1'b1, 8'd0);

      for (int i = 0; i < 18; i++) begin
         drive(1'b0, vecs[i].iv, vecs[i].d, vecs[i].fl, vecs[i].ordy);
         check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed,
                    vecs[i].eocc, vecs[i].erdy, vecs[i].esq);
      end

      // Drive squash_cnt from 4 up to 0xFE with two-entry flushes.
      for (int k = 0; k < 125; k++) begin
         drive(1'b0, 1'b1, 64'(k * 2), 1'b0, 1'b0);
         drive(1'b0, 1'b1, 64'(k * 2 + 1), 1'b0, 1'b0);
         drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      end
      check("sat.pre", 64'(squash_cnt), 64'hFE);
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b1, 64'hE0, 1'b0, 1'b0);
         drive(1'b0, 1'b1, 64'hE1, 1'b0, 1'b0);
         check("sat.two_held", 64'(occ), 64'd2);
         drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
         check($sformatf("sat.clamp%0d", k), 64'(squash_cnt), 64'hFF);
      end

      // Reset while full and flushing: nothing counted, nothing leaks.
      drive(1'b0, 1'b1, 64'hD1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 64'hD2, 1'b0, 1'b0);
      check("rst_two.occ", 64'(occ), 64'd2);
      drive(1'b1, 1'b1, 64'hD3, 1'b1, 1'b1);
      check_outs("rst_two", 1'b0, BUBBLE, 2'd0, 1'b1, 8'd0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
         check_outs($sformatf("post_rst%0d", k), 1'b0, BUBBLE, 2'd0, 1'b1, 8'd0);
      end

      @(negedge clk);
      mon_en = 0;
      if (sb_q.size() != 0) check("sb.drained", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
